hop_chain_seq: RTL and testbench
================================

Name: hop_chain_seq

Overview:
- Upstream driver and return monitor for the hop flop-chain benchmarks.
- Holds each chain reset, then releases the chain resets one by one in index order with a fixed gap.
- Once all resets are released, launches a single-cycle start pulse into the chain and counts cycles until the chain output returns.
- Compares the measured latency against the expected hop count and reports pass/fail, or a timeout.

Parameters:
- N_RST, 6, number of chain reset outputs (rst_out[0] drives the first chain reset).
- RST_CYCLES, 4, cycles all rst_out stay high after go, before the first release (min 1).
- RELEASE_GAP, 2, cycles between consecutive rst_out bit releases (min 1).
- EXP_LAT, 7, expected start-to-return latency in cycles.
- TIMEOUT, 64, max cycles waited for the return (must be > EXP_LAT).
- LAT_W, 8, latency counter width (2^LAT_W > TIMEOUT).

Ports:
- clock0, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- go, input, 1, run request; sampled only in IDLE.
- hop_out, input, 1, chain output (final stage flop).
- rst_out, output, N_RST, chain reset drives, active high.
- start, output, 1, registered single-cycle start pulse.
- busy, output, 1, high in every state except IDLE and DONE.
- done, output, 1, one-cycle pulse on entry to DONE.
- pass, output, 1, result; valid from the done pulse until the next go.
- timeout, output, 1, result; valid from the done pulse until the next go.
- latency, output, LAT_W, measured latency; valid from the done pulse until the next go.

Behaviour:
- Reset values (any cycle rst is high, including mid-run): state IDLE, rst_out all ones, start=0, busy=0, done=0, pass=0, timeout=0, latency=0, all counters 0.
- All outputs are registered.
- IDLE:
  - rst_out all ones.
  - go=1 -> HOLD; the same edge clears pass, timeout and latency.
- HOLD:
  - rst_out all ones for RST_CYCLES cycles, then -> RELEASE.
- RELEASE:
  - Clear rst_out[0]; then clear rst_out[k] exactly RELEASE_GAP cycles after rst_out[k-1].
  - A released bit never re-asserts within a run.
  - RELEASE_GAP cycles after rst_out[N_RST-1] clears -> ARM.
- ARM (1 cycle):
  - If hop_out=1 -> DONE with pass=0, timeout=0, latency=0 (stuck chain).
  - Else -> PULSE.
- PULSE (1 cycle):
  - start=1 for exactly this cycle (cycle 0); lat counter set to 0 -> WAIT.
- WAIT:
  - Counter increments each cycle; cycle 1 is the first WAIT cycle.
  - The first cycle with hop_out=1 -> DONE, latency = cycle index, pass = (latency == EXP_LAT), timeout=0.
  - A 7-flop chain returns at cycle 7.
  - If counter reaches TIMEOUT with no return -> DONE, timeout=1, pass=0, latency=TIMEOUT.
  - hop_out and the timeout limit in the same cycle: return wins.
- DONE:
  - done=1 for one cycle, then hold results.
  - go=1 -> HOLD (new run; rst_out goes all ones again).
  - go is ignored in all other states.
- Counters saturate and never wrap. The latency counter is compared against TIMEOUT before it can overflow.

Optional Feature:
- Macro: HOP_CHAIN_SEQ_REPEAT_EN.
- Defined:
  - Adds input repeat (1b) and output err_cnt (8b, reset 0).
  - In DONE with repeat=1, the block auto-returns to HOLD the next cycle without go.
  - err_cnt increments on each done with pass=0 and saturates at 255.
  - err_cnt clears only on rst.
- Undefined:
  - No extra ports; single-shot behaviour as above.

Test Plan:
- go pulse, 7-flop chain model on hop_out -> rst_out releases rst_out[0] at cycle 4 after HOLD entry, then one bit every 2 cycles; start high 1 cycle; done with latency=7, pass=1, timeout=0.
- Chain model with 5 stages -> done, latency=5, pass=0, timeout=0.
- hop_out tied 0 -> done at WAIT cycle 64, timeout=1, pass=0, latency=64.
- hop_out tied 1 -> done after ARM, latency=0, pass=0, start never asserted.
- rst asserted during RELEASE with rst_out=6'b111100 -> next cycle rst_out=6'b111111, busy=0, state IDLE; go during WAIT has no effect on results.
- REPEAT_EN, repeat=1, 5-stage model for 3 runs -> three done pulses without go, err_cnt=3.

Source files
------------

// File: rtl/hop_chain_seq.sv
// Hop flop-chain driver: staged reset release, start pulse, return latency check.
// Optional HOP_CHAIN_SEQ_REPEAT_EN adds auto-repeat runs and an error counter.
module hop_chain_seq #(
  parameter int N_RST       = 6,
  parameter int RST_CYCLES  = 4,
  parameter int RELEASE_GAP = 2,
  parameter int EXP_LAT     = 7,
  parameter int TIMEOUT     = 64,
  parameter int LAT_W       = 8
) (
  input  logic             clock0,
  input  logic             rst,
  input  logic             go,
  input  logic             hop_out,
`ifdef HOP_CHAIN_SEQ_REPEAT_EN
  input  logic             repeat_i,
  output logic [7:0]       err_cnt,
`endif
  output logic [N_RST-1:0] rst_out,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [LAT_W-1:0] latency
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RELEASE,
    S_ARM,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int PH_MAX =
    (RST_CYCLES > RELEASE_GAP) ? RST_CYCLES : RELEASE_GAP;
  localparam int PH_W = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] HOLD_LAST =
    PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST =
    PH_W'(RELEASE_GAP - 1);
  localparam logic [LAT_W-1:0] LAT_TO =
    LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] LAT_EXP =
    LAT_W'(EXP_LAT);

  state_e             state_q;
  logic [PH_W-1:0]    ph_q;
  logic [LAT_W-1:0]   lat_q;
  logic [N_RST-1:0]   rst_out_q;
  logic               start_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               timeout_q;
  logic [LAT_W-1:0]   latency_q;
  logic               rpt_w;
  logic               launch_d;

`ifdef HOP_CHAIN_SEQ_REPEAT_EN
  assign rpt_w = repeat_i;
`else
  assign rpt_w = 1'b0;
`endif

  always_comb begin
    launch_d = 1'b0;
    if (state_q == S_IDLE)
      launch_d = go;
    else if (state_q == S_DONE)
      launch_d = go | rpt_w;
  end

  always_ff @(posedge clock0) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      lat_q     <= '0;
      rst_out_q <= '1;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      latency_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (launch_d) begin
        state_q   <= S_HOLD;
        busy_q    <= 1'b1;
        ph_q      <= '0;
        lat_q     <= '0;
        rst_out_q <= '1;
        pass_q    <= 1'b0;
        timeout_q <= 1'b0;
        latency_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: rst_out_q <= '1;
          S_HOLD: begin
            if (ph_q == HOLD_LAST) begin
              ph_q      <= '0;
              rst_out_q <= rst_out_q << 1;
              state_q   <= S_RELEASE;
            end else begin
              ph_q <= ph_q + 1'b1;
            end
          end
          // Bits clear low-to-high; all-zero plus one gap means done.
          S_RELEASE: begin
            if (ph_q == GAP_LAST) begin
              ph_q <= '0;
              if (rst_out_q == '0)
                state_q <= S_ARM;
              else
                rst_out_q <= rst_out_q << 1;
            end else begin
              ph_q <= ph_q + 1'b1;
            end
          end
          S_ARM: begin
            if (hop_out) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= 1'b0;
              timeout_q <= 1'b0;
              latency_q <= '0;
            end else begin
              state_q <= S_PULSE;
              start_q <= 1'b1;
              lat_q   <= '0;
            end
          end
          S_PULSE: begin
            state_q <= S_WAIT;
            lat_q   <= lat_q + 1'b1;
          end
          S_WAIT: begin
            if (hop_out) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              latency_q <= lat_q;
              pass_q    <= (lat_q == LAT_EXP);
              timeout_q <= 1'b0;
            end else if (lat_q == LAT_TO) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              latency_q <= LAT_TO;
              pass_q    <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
          S_DONE: state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef HOP_CHAIN_SEQ_REPEAT_EN
  logic [7:0] err_q;

  always_ff @(posedge clock0) begin
    if (rst)
      err_q <= '0;
    else if (done_q && !pass_q && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`endif

  assign rst_out = rst_out_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign latency = latency_q;

endmodule

// File: tb/tb_hop_chain_seq.sv
// Scoreboard bench for hop_chain_seq with a behavioural flop-chain model.
// Exercises HOP_CHAIN_SEQ_REPEAT_EN when that macro is defined.
module tb_hop_chain_seq;

  typedef struct packed {
    logic [7:0] lat;
    logic       p;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       hop_out;
  logic [5:0] rst_out;
  logic       start, busy, done, pass, timeout;
  logic [7:0] latency;
`ifdef HOP_CHAIN_SEQ_REPEAT_EN
  logic       rpt = 1'b0;
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  hop_chain_seq #(
    .N_RST(6), .RST_CYCLES(4), .RELEASE_GAP(2),
    .EXP_LAT(7), .TIMEOUT(64), .LAT_W(8)
  ) dut (
    .clock0  (clk),
    .rst     (rst),
    .go      (go),
    .hop_out (hop_out),
`ifdef HOP_CHAIN_SEQ_REPEAT_EN
    .repeat_i(rpt),
    .err_cnt (err_cnt),
`endif
    .rst_out (rst_out),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .timeout (timeout),
    .latency (latency)
  );

  // mode 0: chain model, 1: tied low, 2: tied high
  int          chain_mode = 1;
  int          chain_len = 7;
  logic [15:0] sr = '0;

  always @(posedge clk) begin
    if (|rst_out) sr <= '0;
    else sr <= {sr[14:0], start};
  end

  always_comb begin
    hop_out = 1'b0;
    if (chain_mode == 2) hop_out = 1'b1;
    else if (chain_mode == 0) hop_out = sr[chain_len-1];
  end

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (start) start_cnt++;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        e = sb.pop_front();
        chk("done_latency", latency, e.lat);
        chk("done_pass", pass, e.p);
        chk("done_timeout", timeout, e.t);
      end
    end
  end

  function automatic logic [5:0] exp_rst(input int c);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = (c < 4 + 2*k);
    return r;
  endfunction

  task automatic do_run(input int mode, input int len,
                        input int e_lat, input bit e_p,
                        input bit e_t, input int e_starts,
                        input bit chk_seq, input bit go_wait);
    exp_t e;
    bit   seen;
    chain_mode = mode;
    chain_len = len;
    e.lat = 8'(e_lat);
    e.p = e_p;
    e.t = e_t;
    sb.push_back(e);
    start_cnt = 0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("busy_run", busy, 1);
    if (chk_seq)
      for (int k = 0; k < 17; k++) begin
        chk($sformatf("rst_out_c%0d", k), rst_out, exp_rst(k));
        @(negedge clk);
      end
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done) seen = 1;
      else begin
        if (go_wait && c >= 3) go = 1'b1;
        @(negedge clk);
      end
    end
    go = 1'b0;
    if (!seen) begin
      n_tot++;
      $display("FAIL done_wait: got no done expected done within 200");
    end
    chk("start_pulses", start_cnt, e_starts);
    repeat (3) @(negedge clk);
    chk("hold_latency", latency, e_lat);
    chk("hold_pass", pass, e_p);
    chk("hold_timeout", timeout, e_t);
    chk("hold_busy", busy, 0);
    chk("hold_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_rst_out", rst_out, 6'h3F);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", start, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_latency", latency, 0);
`ifdef HOP_CHAIN_SEQ_REPEAT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_rst_out", rst_out, 6'h3F);
    chk("idle_busy", busy, 0);

    do_run(0, 7, 7, 1, 0, 1, 1, 0);
    do_run(0, 5, 5, 0, 0, 1, 0, 0);
    do_run(1, 7, 64, 0, 1, 1, 0, 0);
    do_run(2, 7, 0, 0, 0, 0, 0, 0);

    // reset mid-release
    chain_mode = 0;
    chain_len = 7;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (rst_out == 6'b111100) found = 1;
      else @(negedge clk);
    end
    if (!found) begin
      n_tot++;
      $display("FAIL mid_rst_wait: got no 111100 expected 111100");
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rst_out", rst_out, 6'h3F);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_latency", latency, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    do_run(0, 7, 7, 1, 0, 1, 1, 1);

`ifdef HOP_CHAIN_SEQ_REPEAT_EN
    chk("pre_rep_err_cnt", err_cnt, 0);
    chain_mode = 0;
    chain_len = 5;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.lat = 8'd5; e.p = 1'b0; e.t = 1'b0;
      sb.push_back(e);
    end
    begin
      int d0;
      d0 = done_cnt;
      rpt = 1'b1;
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      for (int c = 0; c < 400 && rpt; c++) begin
        @(negedge clk);
        if (done && done_cnt - d0 >= 3) rpt = 1'b0;
      end
      rpt = 1'b0;
      repeat (5) @(negedge clk);
      chk("rep_done_count", done_cnt - d0, 3);
      chk("rep_err_cnt", err_cnt, 3);
      chk("rep_busy", busy, 0);
    end
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
